// File: rtl/bcd_serial_adder_ctrl.sv
// rtl/bcd_serial_adder_ctrl.sv - digit-serial multi-digit BCD adder sequencer
// One BCD add-and-correct cell is stepped LSD-first across DIGITS digits.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    res;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            err_acc;

    logic [4:0]      t;
    logic [3:0]      digit;
    logic            carry_nx;
    logic [W-1:0]    res_nx;
    logic            in_err;
    logic            last;

    always_comb begin
        t        = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
        digit    = t[3:0];
        carry_nx = 1'b0;
        // Applied to any t>9, including sums built from invalid digits.
        if (t > 5'd9) begin
            digit    = t[3:0] + 4'd6;
            carry_nx = 1'b1;
        end
        res_nx             = res;
        res_nx[idx*4 +: 4] = digit;
        last               = (idx == IW'(DIGITS - 1));
    end

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                in_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            err_acc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        res     <= '0;
                        carry   <= 1'b0;
                        idx     <= '0;
                        err_acc <= in_err;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    res   <= res_nx;
                    carry <= carry_nx;
                    if (last) begin
                        idx   <= '0;
                        sum   <= res_nx;
                        cout  <= carry_nx;
                        err   <= err_acc;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb/tb_bcd_serial_adder_ctrl.sv - scoreboard bench for bcd_serial_adder_ctrl
module tb_bcd_serial_adder_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int tests = 0;
    int fails = 0;
    logic [17:0] exp_q[$];
    logic [17:0] prev;

    bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_done", {14'b0, sum, cout, err}, 32'h0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk({sum, cout, err} == e, "result", {14'b0, sum, cout, err}, {14'b0, e});
            end
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_in,
                          input logic [15:0] es, input logic ec, input logic ee,
                          input bit inject);
        int busy_cnt;
        bit got;
        bit held;
        @(negedge clk);
        a = ta; b = tb_in; start = 1'b1;
        exp_q.push_back({es, ec, ee});
        @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        busy_cnt = 0; got = 0; held = 1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (done) begin
                got = 1;
            end else begin
                if (busy) busy_cnt++;
                if ({sum, cout, err} != prev) held = 0;
                if (inject && i == 1) begin
                    a = 16'h9999; b = 16'h9999; start = 1'b1;
                end
                if (inject && i == 2) start = 1'b0;
                @(negedge clk);
            end
        end
        chk(got, "done_timeout", {31'b0, got}, 32'h1);
        chk(busy_cnt == 4, "busy_cycles", busy_cnt, 32'd4);
        chk(held, "outputs_held", {14'b0, sum, cout, err}, {14'b0, prev});
        prev = {es, ec, ee};
    endtask

    task automatic run_cont();
        int dones;
        int last_cyc;
        bit gap_ok;
        bit busy_ok;
        @(negedge clk);
        a = 16'h0005; b = 16'h0005; start = 1'b1;
        repeat (3) exp_q.push_back({16'h0010, 1'b0, 1'b0});
        dones = 0; last_cyc = -1; gap_ok = 1; busy_ok = 1;
        for (int cyc = 1; cyc < 60 && dones < 3; cyc++) begin
            @(negedge clk);
            if (busy == done) busy_ok = 0;
            if (done) begin
                dones++;
                if (last_cyc >= 0 && cyc - last_cyc != 5) gap_ok = 0;
                last_cyc = cyc;
                if (dones == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk(dones == 3, "cont_done_count", dones, 32'd3);
        chk(gap_ok, "cont_period", {31'b0, gap_ok}, 32'h1);
        chk(busy_ok, "cont_busy", {31'b0, busy_ok}, 32'h1);
        prev = {16'h0010, 1'b0, 1'b0};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        prev = '0;
        repeat (2) @(negedge clk);
        chk({busy, done, sum, cout, err} == 20'h0, "reset_state", {12'b0, busy, done, sum, cout, err}, 32'h0);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 0);
        run_op(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h5555, 16'h4445, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h000A, 16'h0000, 16'h0010, 1'b0, 1'b1, 0);
        run_op(16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 16'h5554, 1'b1, 1'b1, 0);
        run_op(16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1);
        repeat (8) @(negedge clk);
        run_cont();
        repeat (3) @(negedge clk);

        @(negedge clk);
        a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk({busy, done, sum, cout, err} == 20'h0, "reset_mid_run", {12'b0, busy, done, sum, cout, err}, 32'h0);
        prev = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 0);

        repeat (10) @(negedge clk);
        chk(exp_q.size() == 0, "pending_results", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
